prog_loader: RTL and testbench
==============================

# prog_loader

Serial program/data loader that sits directly downstream of the FPGA demo driver and upstream of the tiny processor's instruction and data memories. It edge-detects the driver's serial clock and shifts in 12-bit LSB-first frames (address in the low nibble, byte in the high byte). Each complete frame becomes a one-cycle write into IMEM or DMEM, selected by the mode lines. It reports load completion and program halt back on `done_out`, and gates core execution in run mode.

## Interface
- `ADDR_W`, default 4: memory address width (16 entries).
- `DATA_W`, default 8: memory word width.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sclk_in` in 1: serial clock from the driver; sampled as data, not used as a clock.
- `mosi_in` in 1: serial data, LSB first.
- `mode_in` in 2: 00 idle, 01 IMEM load, 10 DMEM load, 11 run.
- `halt_in` in 1: core has executed halt.
- `imem_we_out` out 1: IMEM write strobe, one cycle.
- `dmem_we_out` out 1: DMEM write strobe, one cycle.
- `mem_addr_out` out `ADDR_W`: write address.
- `mem_wdata_out` out `DATA_W`: write data.
- `run_out` out 1: core enable.
- `done_out` out 1: load complete (load modes) or halted (run mode).
- `err_out` out 1: one-cycle pulse on an aborted frame.

## Operation
- `FRAME_BITS = ADDR_W + DATA_W` (12). Frame bit k is sampled from the k-th sclk rising edge. Bits [3:0] are the address; bits [11:4] are the data.
- Rising edge is detected as `sclk_q == 0 && sclk_in == 1`, where `sclk_q` is `sclk_in` registered. `mosi_in` is sampled in the same cycle.
- **IDLE**
  - `mode_in` of 01 or 10: latch the target (`tgt = mode_in`), clear the bit counter and shift register, go to SHIFT. If `tgt` differs from the previous target, clear `done_out`.
  - `mode_in` of 11: go to RUN.
- **SHIFT**
  - On each rising edge, `shreg[bitcnt] <= mosi_in` and `bitcnt` increments. `bitcnt` is 4 bits, saturating at `FRAME_BITS`.
  - When `bitcnt == FRAME_BITS`, go to COMMIT.
  - If `mode_in != tgt` before 12 bits arrive: pulse `err_out`, make no write, go to IDLE.
  - A rising edge coincident with the mode change is ignored.
- **COMMIT** (exactly one cycle)
  - Drive the `tgt` write strobe with `mem_addr_out = shreg[3:0]` and `mem_wdata_out = shreg[11:4]`.
  - If the address is all-ones, set `done_out`.
  - Go to WAIT.
- **WAIT**: hold until `mode_in == 00`, then go to IDLE. This provides inter-frame separation.
- **RUN**
  - `run_out = 1` and `done_out = 0` on entry.
  - `halt_in` sets `done_out` and clears `run_out`.
  - `mode_in == 00` clears both flags and returns to IDLE.
  - `mode_in` of 01 or 10 in RUN is ignored.
- Frames to an already written address overwrite it. No write count is enforced.

## Timing
- Reset: state IDLE; all outputs 0; `shreg`, `bitcnt`, `tgt`, `sclk_q` are 0.
- Reset mid-frame or mid-run discards the partial frame. No strobe or error is issued.
- Write latency: the strobe is asserted in the cycle after the cycle that samples bit 11.
- Strobes never assert together.
- `mem_addr_out` and `mem_wdata_out` are valid only while a strobe is high. They hold their last value otherwise.
- `done_out` is a registered level. In a load mode it stays high until the target changes, RUN is entered, or reset.
- `run_out` rises the cycle after RUN is entered and falls the cycle after `halt_in` is seen.
- Minimum legal sclk period: 2 clk cycles. This is the driver's toggle-per-clk rate.

## Configuration
- `PROG_LOADER_SYNC_EN` defined:
  - `sclk_in`, `mosi_in` and `mode_in` each pass through 2-flop synchronizers before edge detection.
  - All latencies grow by 2 cycles.
  - The minimum sclk period becomes 4 clk cycles.
- Not defined: inputs go directly to the edge detector. This is for the same-clock driver in the demo.

## Structure
- Package `prog_loader_pkg` holds:
  - `loader_state_t` with states IDLE, SHIFT, COMMIT, WAIT, RUN.
  - Constants `MODE_IDLE=2'b00`, `MODE_IMEM=2'b01`, `MODE_DMEM=2'b10`, `MODE_RUN=2'b11`.
  - Function `frame_bits(addr_w, data_w)`.
- Sub-module `sclk_edge_det`: holds the optional synchronizers (under the macro) and the rising-edge pulse. It outputs synced `mosi` and `mode` plus `sclk_rise`.

## Test plan
- IMEM frame 12'hA53, LSB first, bits 1,1,0,0,1,0,1,0,0,1,0,1, mode 01 → one `imem_we_out` pulse with addr 3, data 8'hA5; `dmem_we_out` stays 0.
- 16 DMEM frames, addr 0..15, data = addr ^ 8'h5A → 16 `dmem_we_out` pulses with matching values; `done_out` rises on the cycle addr 15 commits.
- Mode drops 10→00 after 7 bits → one `err_out` pulse, no strobe; the next full frame 12'h01F writes addr 15, data 8'h01.
- Mode 11 after the loads → `run_out` = 1, `done_out` = 0; `halt_in` pulse → `done_out` = 1, `run_out` = 0; mode 00 → both 0, state IDLE.
- `rst` asserted after bit 9 of a frame → all outputs 0 next cycle; a following complete frame 12'h7E2 writes addr 2, data 8'h7E.
- With `PROG_LOADER_SYNC_EN`: frame 12'hA53 → strobe 2 cycles later than the unsynchronized build, same addr and data.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program/data loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    COMMIT,
    WAIT,
    RUN
  } loader_state_t;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_IMEM = 2'b01;
  localparam logic [1:0] MODE_DMEM = 2'b10;
  localparam logic [1:0] MODE_RUN  = 2'b11;

  function automatic int frame_bits(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Memory write bus from the loader to the core's IMEM/DMEM.
interface prog_loader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) ();

  logic              imem_we_out;
  logic              dmem_we_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;

  modport master (
    output imem_we_out,
    output dmem_we_out,
    output mem_addr_out,
    output mem_wdata_out
  );

  modport slave (
    input imem_we_out,
    input dmem_we_out,
    input mem_addr_out,
    input mem_wdata_out
  );

endinterface

// File: rtl/prog_loader_sclk_edge_det.sv
// Serial clock rising-edge detector with optional 2-flop input synchronizers.
// Build option: PROG_LOADER_SYNC_EN adds synchronizers on sclk, mosi and mode.
module sclk_edge_det (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic [1:0] mode_in,
  output logic       sclk_rise,
  output logic       mosi,
  output logic [1:0] mode
);

  logic sclk_s;
  logic sclk_q;

`ifdef PROG_LOADER_SYNC_EN
  logic [1:0] sclk_sync;
  logic [1:0] mosi_sync;
  logic [1:0] mode_s1;
  logic [1:0] mode_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      mode_s1   <= '0;
      mode_s2   <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk_in};
      mosi_sync <= {mosi_sync[0], mosi_in};
      mode_s1   <= mode_in;
      mode_s2   <= mode_s1;
    end
  end

  assign sclk_s = sclk_sync[1];
  assign mosi   = mosi_sync[1];
  assign mode   = mode_s2;
`else
  assign sclk_s = sclk_in;
  assign mosi   = mosi_in;
  assign mode   = mode_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) sclk_q <= 1'b0;
    else     sclk_q <= sclk_s;
  end

  assign sclk_rise = sclk_s & ~sclk_q;

endmodule

// File: rtl/prog_loader.sv
// Serial loader: shifts LSB-first {data, addr} frames into IMEM/DMEM writes and gates core run.
// Build option: PROG_LOADER_SYNC_EN (input synchronizers inside sclk_edge_det).
//
//   state  | meaning
//   IDLE   | waiting for a load or run mode
//   SHIFT  | collecting frame bits on sclk rising edges
//   COMMIT | one-cycle write strobe to the latched target
//   WAIT   | frame written, waiting for mode 00 before the next frame
//   RUN    | core enabled until halt or mode 00
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk_in,
  input  logic          mosi_in,
  input  logic [1:0]    mode_in,
  input  logic          halt_in,
  prog_loader_if.master mem,
  output logic          run_out,
  output logic          done_out,
  output logic          err_out
);

  localparam int FRAME_BITS = frame_bits(ADDR_W, DATA_W);
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  logic                  sclk_rise;
  logic                  mosi;
  logic [1:0]            mode;

  loader_state_t         state;
  loader_state_t         state_nxt;
  logic [1:0]            tgt;
  logic [CNT_W-1:0]      bitcnt;
  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] shreg_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  run_q;
  logic                  done_q;
  logic                  err_q;
  logic                  abort;
  logic                  take_bit;
  logic                  last_bit;

  sclk_edge_det u_edge_det (
    .clk       (clk),
    .rst       (rst),
    .sclk_in   (sclk_in),
    .mosi_in   (mosi_in),
    .mode_in   (mode_in),
    .sclk_rise (sclk_rise),
    .mosi      (mosi),
    .mode      (mode)
  );

  // A mode change wins over a coincident sclk edge.
  assign abort    = (state == SHIFT) && (mode != tgt);
  assign take_bit = (state == SHIFT) && !abort && sclk_rise;
  assign last_bit = take_bit && (bitcnt == CNT_W'(FRAME_BITS - 1));

  always_comb begin
    shreg_nxt         = shreg;
    shreg_nxt[bitcnt] = mosi;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mode == MODE_IMEM || mode == MODE_DMEM) state_nxt = SHIFT;
        else if (mode == MODE_RUN)                  state_nxt = RUN;
      end
      SHIFT: begin
        if (abort)         state_nxt = IDLE;
        else if (last_bit) state_nxt = COMMIT;
      end
      COMMIT:  state_nxt = WAIT;
      WAIT:    if (mode == MODE_IDLE) state_nxt = IDLE;
      RUN:     if (mode == MODE_IDLE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.imem_we_out   = (state == COMMIT) && (tgt == MODE_IMEM);
    mem.dmem_we_out   = (state == COMMIT) && (tgt == MODE_DMEM);
    mem.mem_addr_out  = addr_q;
    mem.mem_wdata_out = wdata_q;
  end

  // Address/data are captured as the last bit lands so they are valid with the strobe and hold after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tgt     <= MODE_IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= abort;
      case (state)
        IDLE: begin
          if (mode == MODE_IMEM || mode == MODE_DMEM) begin
            tgt    <= mode;
            bitcnt <= '0;
            shreg  <= '0;
            if (mode != tgt) done_q <= 1'b0;
          end else if (mode == MODE_RUN) begin
            run_q  <= 1'b1;
            done_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (take_bit) begin
            shreg  <= shreg_nxt;
            bitcnt <= (bitcnt == CNT_W'(FRAME_BITS)) ? bitcnt : bitcnt + 1'b1;
          end
          if (last_bit) begin
            addr_q  <= shreg_nxt[ADDR_W-1:0];
            wdata_q <= shreg_nxt[FRAME_BITS-1:ADDR_W];
            if (&shreg_nxt[ADDR_W-1:0]) done_q <= 1'b1;
          end
        end
        RUN: begin
          if (mode == MODE_IDLE) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
          end else if (halt_in) begin
            run_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign run_out  = run_q;
  assign done_out = done_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader: IMEM/DMEM frames, abort, run/halt, mid-frame reset.
module tb_prog_loader;
  import prog_loader_pkg::*;

`ifdef PROG_LOADER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif
  localparam int HP = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk_in;
  logic       mosi_in;
  logic [1:0] mode_in;
  logic       halt_in;
  logic       run_out;
  logic       done_out;
  logic       err_out;

  int n_total    = 0;
  int n_pass     = 0;
  int n_fail     = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(4), .DATA_W(8)) mem_if ();

  prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk_in  (sclk_in),
    .mosi_in  (mosi_in),
    .mode_in  (mode_in),
    .halt_in  (halt_in),
    .mem      (mem_if),
    .run_out  (run_out),
    .done_out (done_out),
    .err_out  (err_out)
  );

  // Counts pulses seen during the cycle that just ended.
  always @(posedge clk) begin
    if (mem_if.imem_we_out || mem_if.dmem_we_out) strobe_cnt <= strobe_cnt + 1;
    if (err_out) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sclk_in = 1'b0;
    mosi_in = b;
    repeat (HP) @(negedge clk);
    sclk_in = 1'b1;
  endtask

  task automatic send_frame(input logic [11:0] f, input logic exp_imem, input logic [3:0] exp_addr,
                            input logic [7:0] exp_data, input logic exp_done, input string tag);
    int cnt0;
    for (int i = 0; i < 12; i++) begin
      send_bit(f[i]);
      if (i == 11) begin
        cnt0 = strobe_cnt;
        repeat (LAT) @(negedge clk);
        chk({tag, " no_early"}, strobe_cnt, cnt0);
        chk({tag, " imem_we"}, {31'b0, mem_if.imem_we_out}, {31'b0, exp_imem});
        chk({tag, " dmem_we"}, {31'b0, mem_if.dmem_we_out}, {31'b0, !exp_imem});
        chk({tag, " addr"}, {28'b0, mem_if.mem_addr_out}, {28'b0, exp_addr});
        chk({tag, " data"}, {24'b0, mem_if.mem_wdata_out}, {24'b0, exp_data});
        chk({tag, " done"}, {31'b0, done_out}, {31'b0, exp_done});
        @(negedge clk);
        chk({tag, " one_pulse"}, {30'b0, mem_if.imem_we_out, mem_if.dmem_we_out}, 32'd0);
        chk({tag, " count"}, strobe_cnt, cnt0 + 1);
      end else begin
        repeat (HP) @(negedge clk);
      end
    end
    @(negedge clk);
    sclk_in = 1'b0;
    mode_in = MODE_IDLE;
    repeat (4) @(negedge clk);
  endtask

  logic [11:0] part;
  logic [7:0]  dval;
  int          cnt_s;
  int          cnt_e;

  initial begin
    rst     = 1'b1;
    sclk_in = 1'b0;
    mosi_in = 1'b0;
    mode_in = MODE_IDLE;
    halt_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst imem_we", {31'b0, mem_if.imem_we_out}, 32'd0);
    chk("rst dmem_we", {31'b0, mem_if.dmem_we_out}, 32'd0);
    chk("rst addr", {28'b0, mem_if.mem_addr_out}, 32'd0);
    chk("rst data", {24'b0, mem_if.mem_wdata_out}, 32'd0);
    chk("rst run", {31'b0, run_out}, 32'd0);
    chk("rst done", {31'b0, done_out}, 32'd0);
    chk("rst err", {31'b0, err_out}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // IMEM frame A53: addr 3, data A5
    mode_in = MODE_IMEM;
    send_frame(12'hA53, 1'b1, 4'h3, 8'hA5, 1'b0, "imem_a53");

    // 16 DMEM frames, data = addr ^ 5A, done with addr 15
    for (int a = 0; a < 16; a++) begin
      dval = 8'(a) ^ 8'h5A;
      @(negedge clk);
      mode_in = MODE_DMEM;
      send_frame({dval, 4'(a)}, 1'b0, 4'(a), dval, (a == 15), $sformatf("dmem_%0d", a));
    end
    chk("done held after load", {31'b0, done_out}, 32'd1);

    // abort after 7 bits
    cnt_s = strobe_cnt;
    cnt_e = err_cnt;
    part  = 12'h3C6;
    @(negedge clk);
    mode_in = MODE_DMEM;
    for (int i = 0; i < 7; i++) begin
      send_bit(part[i]);
      repeat (HP) @(negedge clk);
    end
    @(negedge clk);
    sclk_in = 1'b0;
    mode_in = MODE_IDLE;
    repeat (LAT) @(negedge clk);
    chk("abort err_out", {31'b0, err_out}, 32'd1);
    chk("abort err not early", err_cnt, cnt_e);
    @(negedge clk);
    chk("abort err one pulse", {31'b0, err_out}, 32'd0);
    repeat (3) @(negedge clk);
    chk("abort no strobe", strobe_cnt, cnt_s);
    chk("abort err count", err_cnt, cnt_e + 1);
    chk("abort done kept", {31'b0, done_out}, 32'd1);
    mode_in = MODE_DMEM;
    send_frame(12'h01F, 1'b0, 4'hF, 8'h01, 1'b1, "dmem_01f");

    // run / halt
    @(negedge clk);
    mode_in = MODE_RUN;
    repeat (LAT) @(negedge clk);
    chk("run entry run", {31'b0, run_out}, 32'd1);
    chk("run entry done", {31'b0, done_out}, 32'd0);
    @(negedge clk);
    mode_in = MODE_IMEM;
    repeat (4) @(negedge clk);
    chk("run ignores load", {31'b0, run_out}, 32'd1);
    mode_in = MODE_RUN;
    repeat (4) @(negedge clk);
    halt_in = 1'b1;
    @(negedge clk);
    halt_in = 1'b0;
    chk("halt done", {31'b0, done_out}, 32'd1);
    chk("halt run", {31'b0, run_out}, 32'd0);
    repeat (2) @(negedge clk);
    chk("halt done held", {31'b0, done_out}, 32'd1);
    mode_in = MODE_IDLE;
    repeat (LAT) @(negedge clk);
    chk("run exit run", {31'b0, run_out}, 32'd0);
    chk("run exit done", {31'b0, done_out}, 32'd0);
    repeat (3) @(negedge clk);

    // reset after bit 9
    cnt_s   = strobe_cnt;
    cnt_e   = err_cnt;
    part    = 12'h5CF;
    mode_in = MODE_IMEM;
    for (int i = 0; i < 10; i++) begin
      send_bit(part[i]);
      repeat (HP) @(negedge clk);
    end
    @(negedge clk);
    rst     = 1'b1;
    sclk_in = 1'b0;
    mode_in = MODE_IDLE;
    @(negedge clk);
    chk("midrst imem_we", {31'b0, mem_if.imem_we_out}, 32'd0);
    chk("midrst dmem_we", {31'b0, mem_if.dmem_we_out}, 32'd0);
    chk("midrst addr", {28'b0, mem_if.mem_addr_out}, 32'd0);
    chk("midrst data", {24'b0, mem_if.mem_wdata_out}, 32'd0);
    chk("midrst run", {31'b0, run_out}, 32'd0);
    chk("midrst done", {31'b0, done_out}, 32'd0);
    chk("midrst err", {31'b0, err_out}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst no strobe", strobe_cnt, cnt_s);
    chk("midrst no err", err_cnt, cnt_e);
    mode_in = MODE_IMEM;
    send_frame(12'h7E2, 1'b1, 4'h2, 8'h7E, 1'b0, "imem_7e2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
